// File: rtl/fifo_read_ctrl_if.sv
// Read-side handshake bundle of the async FIFO: consumer request/flags plus the
// Gray pointer pair exchanged with the write-domain synchronizers.
interface fifo_read_ctrl_if #(
   parameter int ADDRESS_BITS = 4
);
   logic                    read_en;
   logic                    underflow_clr;
   logic [ADDRESS_BITS:0]   rq2_write_ptr;
   logic [ADDRESS_BITS-1:0] read_addr;
   logic [ADDRESS_BITS:0]   read_ptr;
   logic                    empty;
   logic                    almost_empty;
   logic [ADDRESS_BITS:0]   read_count;
   logic                    underflow;

   modport master (
      output read_en,
      output underflow_clr,
      output rq2_write_ptr,
      input  read_addr,
      input  read_ptr,
      input  empty,
      input  almost_empty,
      input  read_count,
      input  underflow
   );

   modport slave (
      input  read_en,
      input  underflow_clr,
      input  rq2_write_ptr,
      output read_addr,
      output read_ptr,
      output empty,
      output almost_empty,
      output read_count,
      output underflow
   );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-domain controller: binary/Gray read pointers, memory read
// address, and empty / almost-empty / fill-count / sticky underflow flags.
module fifo_read_ctrl #(
   parameter int ADDRESS_BITS       = 4,
   parameter int ALMOST_EMPTY_LEVEL = 2
) (
   input logic              read_clk,
   input logic              read_rst,
   fifo_read_ctrl_if.slave  bus
);
   localparam int PW = ADDRESS_BITS + 1;
   localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY_LEVEL);
   localparam logic [PW-1:0] ONE      = PW'(1);

   logic [PW-1:0] rbin;
   logic [PW-1:0] rgray;
   logic [PW-1:0] rbin_next;
   logic [PW-1:0] rgray_next;
   logic [PW-1:0] wbin;
   logic [PW-1:0] count_next;
   logic [PW-1:0] count_q;
   logic          empty_q;
   logic          almost_empty_q;
   logic          underflow_q;
   logic          read_inc;
   logic          read_bad;

   // Bit i of the binary value is the XOR of all Gray bits at or above i.
   function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = '0;
      for (int i = 0; i < PW; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   assign read_inc   = bus.read_en & ~empty_q;
   assign read_bad   = bus.read_en & empty_q;
   assign rbin_next  = read_inc ? (rbin + ONE) : rbin;
   assign rgray_next = (rbin_next >> 1) ^ rbin_next;
   assign wbin       = gray_to_bin(bus.rq2_write_ptr);
   assign count_next = wbin - rbin_next;

   always_ff @(posedge read_clk or posedge read_rst) begin
      if (read_rst) begin
         rbin           <= '0;
         rgray          <= '0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         count_q        <= '0;
      end else begin
         rbin           <= rbin_next;
         rgray          <= rgray_next;
         empty_q        <= (rgray_next == bus.rq2_write_ptr);
         almost_empty_q <= (count_next <= AE_LEVEL);
         count_q        <= count_next;
      end
   end

   // A fresh underflow takes priority over a clear in the same cycle.
   always_ff @(posedge read_clk or posedge read_rst) begin
      if (read_rst) begin
         underflow_q <= 1'b0;
      end else if (read_bad) begin
         underflow_q <= 1'b1;
      end else if (bus.underflow_clr) begin
         underflow_q <= 1'b0;
      end
   end

   assign bus.read_addr    = rbin[ADDRESS_BITS-1:0];
   assign bus.read_ptr     = rgray;
   assign bus.empty        = empty_q;
   assign bus.almost_empty = almost_empty_q;
   assign bus.read_count   = count_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Randomized bench for fifo_read_ctrl against an occupancy-level model.
module tb_fifo_read_ctrl;
   localparam int AB    = 4;
   localparam int DEPTH = 1 << AB;
   localparam int AEL   = 2;

   logic read_clk;
   logic read_rst;
   fifo_read_ctrl_if #(.ADDRESS_BITS(AB)) bus ();

   fifo_read_ctrl #(.ADDRESS_BITS(AB), .ALMOST_EMPTY_LEVEL(AEL)) dut (
      .read_clk (read_clk),
      .read_rst (read_rst),
      .bus      (bus)
   );

   initial read_clk = 1'b0;
   always #5 read_clk = ~read_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: total entries made visible by the writer and total entries consumed.
   int m_wv;
   int m_rd;
   int m_count;
   bit m_empty;
   bit m_ae;
   bit m_uf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [AB:0] gray(input int v);
      logic [AB:0] b;
      b = v[AB:0];
      return b ^ (b >> 1);
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".read_addr"},    32'(bus.read_addr),    32'(m_rd % DEPTH));
      check({tag, ".read_ptr"},     32'(bus.read_ptr),     32'(gray(m_rd % (2 * DEPTH))));
      check({tag, ".empty"},        32'(bus.empty),        32'(m_empty));
      check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(m_ae));
      check({tag, ".read_count"},   32'(bus.read_count),   32'(m_count));
      check({tag, ".underflow"},    32'(bus.underflow),    32'(m_uf));
   endtask

   // One read_clk cycle: drive inputs, advance the model, sample 1 ns after the edge.
   task automatic cycle(input bit re, input bit clr, input int wv, input string tag);
      bus.read_en       = re;
      bus.underflow_clr = clr;
      bus.rq2_write_ptr = gray(wv % (2 * DEPTH));
      if (re && m_empty)  m_uf = 1'b1;
      else if (clr)       m_uf = 1'b0;
      if (re && !m_empty) m_rd++;
      m_wv    = wv;
      m_count = m_wv - m_rd;
      m_empty = (m_count == 0);
      m_ae    = (m_count <= AEL);
      @(posedge read_clk);
      #1;
      check_all(tag);
   endtask

   task automatic apply_reset();
      #2;
      read_rst = 1'b1;
      #1;
      m_wv = 0; m_rd = 0; m_count = 0;
      m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
      check_all("rst_async");
      bus.read_en       = 1'b1;
      bus.underflow_clr = 1'b0;
      bus.rq2_write_ptr = '0;
      repeat (2) @(posedge read_clk);
      #1;
      check("rst_hold.read_ptr", 32'(bus.read_ptr), 32'd0);
      check("rst_hold.empty",    32'(bus.empty),    32'd1);
      bus.read_en = 1'b0;
      #3;
      read_rst = 1'b0;
      cycle(1'b0, 1'b0, 0, "rst_release");
   endtask

   initial begin
      int wv;
      bit re, clr;
      read_rst          = 1'b1;
      bus.read_en       = 1'b0;
      bus.underflow_clr = 1'b0;
      bus.rq2_write_ptr = '0;
      m_wv = 0; m_rd = 0; m_count = 0;
      m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
      repeat (2) @(posedge read_clk);
      #1;
      apply_reset();

      // Fill observe, then drain past empty
      cycle(1'b0, 1'b0, 1, "fill1");
      check("fill1.count_const", 32'(bus.read_count), 32'd1);
      cycle(1'b0, 1'b0, 2, "fill2");
      cycle(1'b0, 1'b0, 3, "fill3");
      check("fill3.ae_const", 32'(bus.almost_empty), 32'd0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 3, "drain");
      check("drain.uf_const",  32'(bus.underflow), 32'd1);
      check("drain.ptr_const", 32'(bus.read_ptr),  32'b00010);

      // Underflow clear and set-wins
      cycle(1'b0, 1'b1, 3, "uf_clr");
      cycle(1'b1, 1'b0, 3, "uf_set");
      cycle(1'b1, 1'b1, 3, "uf_setwins");
      check("uf_setwins.const", 32'(bus.underflow), 32'd1);

      // Mid-operation reset, then a completely full FIFO
      apply_reset();
      cycle(1'b0, 1'b0, DEPTH, "full");
      check("full.count_const", 32'(bus.read_count), 32'(DEPTH));

      // Random streaming: several pointer laps, writer never overfills
      wv = DEPTH;
      for (int i = 0; i < 400; i++) begin
         re  = ($urandom_range(0, 99) < 55);
         clr = ($urandom_range(0, 7) == 0);
         if ((wv - m_rd) < DEPTH && $urandom_range(0, 99) < 50) wv++;
         cycle(re, clr, wv, "rand");
      end
      check("rand.laps", 32'(m_rd > 2 * DEPTH), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
